// File: rtl/csa_final_adder.sv
// Two-stage carry-propagate adder that resolves the redundant sum/carry vectors
// of the multiplier compression tree into one binary product.
module csa_final_adder #(
    parameter int WIDTH = 106,
    parameter int SPLIT = 53,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_vec,
    input  logic [WIDTH-1:0] carry_vec,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             result_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int HW = WIDTH - SPLIT;

    logic             v1;
    logic [SPLIT:0]   lo1;
    logic [HW-1:0]    hs1;
    logic [HW-1:0]    hc1;
    logic [TAG_W-1:0] tag1;

    logic             adv1;
    logic             adv2;
    logic             accept;
    logic [HW:0]      hi;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1 && !flush;
    assign accept   = in_valid && in_ready;

    // High segment finishes the carry chain using the registered low-segment carry.
    assign hi = {1'b0, hs1} + {1'b0, hc1} + {{HW{1'b0}}, lo1[SPLIT]};

    // Gated by out_valid so an empty output stage never claims a zero result.
    assign result_zero = out_valid && (result == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            lo1  <= '0;
            hs1  <= '0;
            hc1  <= '0;
            tag1 <= '0;
        end else begin
            if (flush) begin
                v1 <= 1'b0;
            end else if (adv1) begin
                v1 <= in_valid;
            end
            if (accept) begin
                lo1  <= {1'b0, sum_vec[SPLIT-1:0]} + {1'b0, carry_vec[SPLIT-1:0]};
                hs1  <= sum_vec[WIDTH-1:SPLIT];
                hc1  <= carry_vec[WIDTH-1:SPLIT];
                tag1 <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            out_tag   <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (adv2) begin
                out_valid <= v1;
            end
            if (!flush && adv2 && v1) begin
                result  <= {hi[HW-1:0], lo1[SPLIT-1:0]};
                cout    <= hi[HW];
                out_tag <= tag1;
            end
        end
    end

endmodule

// File: tb/tb_csa_final_adder.sv
// Directed bench for csa_final_adder: a table of single operations plus
// hand-written backpressure, flush and asynchronous reset sequences.
module tb_csa_final_adder;

    localparam int WIDTH = 106;
    localparam int SPLIT = 53;
    localparam int TAG_W = 4;
    localparam int NVEC  = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum_vec;
    logic [WIDTH-1:0] carry_vec;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             result_zero;
    logic [TAG_W-1:0] out_tag;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] c;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] r;
        logic             co;
        logic             z;
    } vec_t;

    vec_t vecs [NVEC];
    int   total = 0;
    int   bad   = 0;

    csa_final_adder #(.WIDTH(WIDTH), .SPLIT(SPLIT), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sum_vec    (sum_vec),
        .carry_vec  (carry_vec),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .cout       (cout),
        .result_zero(result_zero),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One operation with out_ready high: result must appear exactly two edges after accept.
    task automatic applyStimulus(input int i);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sum_vec   = vecs[i].s;
        carry_vec = vecs[i].c;
        in_tag    = vecs[i].tag;
        #1;
        checkOutput($sformatf("vec%0d in_ready", i), 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput($sformatf("vec%0d early out_valid", i), 128'(out_valid), 128'(0));
        @(posedge clk); #1;
        checkOutput($sformatf("vec%0d out_valid", i), 128'(out_valid), 128'(1));
        checkOutput($sformatf("vec%0d result", i), 128'(result), 128'(vecs[i].r));
        checkOutput($sformatf("vec%0d cout", i), 128'(cout), 128'(vecs[i].co));
        checkOutput($sformatf("vec%0d result_zero", i), 128'(result_zero), 128'(vecs[i].z));
        checkOutput($sformatf("vec%0d out_tag", i), 128'(out_tag), 128'(vecs[i].tag));
        @(posedge clk); #1;
        checkOutput($sformatf("vec%0d drain", i), 128'(out_valid), 128'(0));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int               sent;
        int               got;
        logic             stalled;
        logic [WIDTH-1:0] held;

        vecs[0] = '{s: 106'h5, c: 106'h3, tag: 4'h2, r: 106'h8, co: 1'b0, z: 1'b0};
        vecs[1] = '{s: {53'b0, {53{1'b1}}}, c: 106'h1, tag: 4'h3,
                    r: {52'b0, 1'b1, 53'b0}, co: 1'b0, z: 1'b0};
        vecs[2] = '{s: {106{1'b1}}, c: 106'h1, tag: 4'h4, r: 106'h0, co: 1'b1, z: 1'b1};
        vecs[3] = '{s: 106'h0, c: 106'h0, tag: 4'h5, r: 106'h0, co: 1'b0, z: 1'b1};
        vecs[4] = '{s: {106{1'b1}}, c: {106{1'b1}}, tag: 4'h6,
                    r: {{105{1'b1}}, 1'b0}, co: 1'b1, z: 1'b0};
        vecs[5] = '{s: {53{2'b10}}, c: {53{2'b01}}, tag: 4'h7,
                    r: {106{1'b1}}, co: 1'b0, z: 1'b0};
        vecs[6] = '{s: {1'b1, 105'b0}, c: {1'b1, 105'b0}, tag: 4'h8,
                    r: 106'h0, co: 1'b1, z: 1'b1};
        vecs[7] = '{s: {53'b0, 1'b1, 52'b0}, c: {53'b0, 1'b1, 52'b0}, tag: 4'h9,
                    r: {52'b0, 1'b1, 53'b0}, co: 1'b0, z: 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        sum_vec   = '0;
        carry_vec = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #2;
        checkOutput("reset out_valid", 128'(out_valid), 128'(0));
        checkOutput("reset in_ready", 128'(in_ready), 128'(1));
        checkOutput("reset result", 128'(result), 128'(0));
        checkOutput("reset cout", 128'(cout), 128'(0));
        checkOutput("reset result_zero", 128'(result_zero), 128'(0));
        checkOutput("reset out_tag", 128'(out_tag), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(i);
        end

        // Backpressure: four ops, out_ready low in cycles 3..5.
        sent    = 0;
        got     = 0;
        stalled = 1'b0;
        held    = '0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (sent < 4);
            sum_vec   = WIDTH'(sent + 1);
            carry_vec = '0;
            in_tag    = TAG_W'(sent + 1);
            #1;
            if (c >= 3 && c <= 5) checkOutput($sformatf("bp in_ready c%0d", c), 128'(in_ready), 128'(0));
            if (c >= 6 && c <= 8) checkOutput($sformatf("bp no gap c%0d", c), 128'(out_valid), 128'(1));
            if (stalled) checkOutput($sformatf("bp stall hold c%0d", c), 128'(result), 128'(held));
            if (out_valid && out_ready) begin
                checkOutput($sformatf("bp result %0d", got), 128'(result), 128'(got + 1));
                checkOutput($sformatf("bp tag %0d", got), 128'(out_tag), 128'(got + 1));
                got++;
            end
            stalled = out_valid && !out_ready;
            held    = result;
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("bp count", 128'(got), 128'(4));
        @(posedge clk); #1;

        // Flush with two ops in flight; the op offered during flush must vanish.
        in_valid = 1'b1; sum_vec = 106'd10; carry_vec = '0; in_tag = 4'h1;
        @(posedge clk); #1;
        sum_vec = 106'd20; in_tag = 4'h2;
        @(posedge clk); #1;
        flush = 1'b1; sum_vec = 106'd30; in_tag = 4'h3;
        #1;
        checkOutput("flush in_ready", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        flush = 1'b0; sum_vec = 106'd40; in_tag = 4'h4;
        checkOutput("flush out_valid cleared", 128'(out_valid), 128'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("flush dropped op", 128'(out_valid), 128'(0));
        @(posedge clk); #1;
        checkOutput("post-flush out_valid", 128'(out_valid), 128'(1));
        checkOutput("post-flush result", 128'(result), 128'(40));
        checkOutput("post-flush tag", 128'(out_tag), 128'(4));
        @(posedge clk); #1;

        // Asynchronous reset between edges while a result is presented.
        in_valid = 1'b1; sum_vec = 106'd7; carry_vec = 106'd9; in_tag = 4'hA;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("pre-reset out_valid", 128'(out_valid), 128'(1));
        checkOutput("pre-reset result", 128'(result), 128'(16));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset out_valid", 128'(out_valid), 128'(0));
        checkOutput("async reset result", 128'(result), 128'(0));
        checkOutput("async reset in_ready", 128'(in_ready), 128'(1));
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
